// File: rtl/orb_reader.sv
// orb_reader: fetches 16-word packets from the orbital RAM and serializes each 12-bit word MSB-first.
// Optional ORB_READER_PARITY_EN appends an odd-parity bit period after each word.
module orb_reader #(
  parameter int WORDS_PER_PACK = 16,
  parameter int PACKS          = 64,
  parameter int BIT_DIV        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clrPack,
  input  logic [11:0] rdData,
  output logic        rdEn,
  output logic [10:0] rdAddr,
  output logic        txBit,
  output logic        txStrb,
  output logic        busy,
  output logic        packDone,
  output logic        fmtErr
);

`ifdef ORB_READER_PARITY_EN
  localparam int NBITS = 13;
`else
  localparam int NBITS = 12;
`endif
  localparam int WW = $clog2(WORDS_PER_PACK);
  localparam int PW = $clog2(PACKS);
  localparam int DW = $clog2(BIT_DIV);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, SHIFT} state_t;

  state_t           state;
  logic [WW-1:0]    cnt_wrd;
  logic [PW-1:0]    cnt_pack;
  logic [DW-1:0]    div;
  logic [3:0]       bit_cnt;
  logic [NBITS-1:0] sr;
  logic [NBITS-1:0] sr_load;
  logic [PW-1:0]    pack_eff;
  logic             last_wrd;
  logic             last_pack;

  // A clear in the same cycle as a fetch redirects that fetch to pack 0.
  assign pack_eff  = clrPack ? '0 : cnt_pack;
  assign last_wrd  = (cnt_wrd == WW'(WORDS_PER_PACK - 1));
  assign last_pack = (cnt_pack == PW'(PACKS - 1));

`ifdef ORB_READER_PARITY_EN
  assign sr_load = {rdData, ~^rdData};
`else
  assign sr_load = rdData;
`endif

  function automatic logic [10:0] addr_of(input logic [PW-1:0] p, input logic [WW-1:0] w);
    return (11'(p) << 5) + (11'(w) << 1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt_wrd  <= '0;
      cnt_pack <= '0;
      div      <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      rdEn     <= 1'b0;
      rdAddr   <= '0;
      txBit    <= 1'b0;
      txStrb   <= 1'b0;
      busy     <= 1'b0;
      packDone <= 1'b0;
      fmtErr   <= 1'b0;
    end else begin
      rdEn     <= 1'b0;
      packDone <= 1'b0;
      fmtErr   <= 1'b0;
      case (state)
        IDLE: begin
          txBit  <= 1'b0;
          txStrb <= 1'b0;
          if (start) begin
            rdEn    <= 1'b1;
            rdAddr  <= addr_of(pack_eff, '0);
            cnt_wrd <= '0;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          sr      <= sr_load;
          bit_cnt <= 4'(NBITS - 1);
          div     <= '0;
          fmtErr  <= rdData[11] | (|rdData[2:0]);
          txStrb  <= 1'b1;
          txBit   <= rdData[11];
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div == DW'(BIT_DIV - 1)) begin
            div <= '0;
            if (bit_cnt != 4'd0) begin
              sr      <= sr << 1;
              bit_cnt <= bit_cnt - 4'd1;
              txStrb  <= 1'b1;
              txBit   <= sr[NBITS-2];
            end else begin
              txStrb <= 1'b0;
              txBit  <= 1'b0;
              if (!last_wrd) begin
                cnt_wrd <= cnt_wrd + 1'b1;
                rdEn    <= 1'b1;
                rdAddr  <= addr_of(pack_eff, cnt_wrd + 1'b1);
                state   <= FETCH;
              end else begin
                cnt_wrd  <= '0;
                cnt_pack <= last_pack ? '0 : cnt_pack + 1'b1;
                packDone <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end
            end
          end else begin
            div    <= div + 1'b1;
            txStrb <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Clear wins over the end-of-packet increment above.
      if (clrPack) cnt_pack <= '0;
    end
  end

endmodule

// File: tb/tb_orb_reader.sv
// Self-checking bench for orb_reader: waveform table for the first word plus packet-level reference model.
module tb_orb_reader;
  localparam int BD = 4;
`ifdef ORB_READER_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif
  localparam int PER  = NB * BD + 2;
  localparam int PKT  = 16 * PER;
  localparam int VLEN = NB * BD + 3;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, clrPack = 1'b0;
  logic [11:0] rdData = '0;
  logic rdEn, txBit, txStrb, busy, packDone, fmtErr;
  logic [10:0] rdAddr;

  orb_reader #(.WORDS_PER_PACK(16), .PACKS(64), .BIT_DIV(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .clrPack(clrPack), .rdData(rdData),
    .rdEn(rdEn), .rdAddr(rdAddr), .txBit(txBit), .txStrb(txStrb),
    .busy(busy), .packDone(packDone), .fmtErr(fmtErr)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [0:2047];
  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log: only appended here, the test reads tails from recorded start indices.
  logic [10:0] addr_q[$];
  int          rd_cyc_q[$];
  bit          bit_q[$];
  int          err_q[$];
  always @(negedge clk) if (rst) begin
    if (rdEn) begin addr_q.push_back(rdAddr); rd_cyc_q.push_back(cyc); end
    if (txStrb) bit_q.push_back(txBit);
    if (fmtErr) err_q.push_back(cyc);
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit          rd_en;
    logic [10:0] addr;
    bit          strb;
    bit          txb;
    bit          bsy;
  } vec_t;
  vec_t vec[VLEN];

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rdEn"}, rdEn, 0);
    chk({tag, "_rdAddr"}, rdAddr, 0);
    chk({tag, "_txBit"}, txBit, 0);
    chk({tag, "_txStrb"}, txStrb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_packDone"}, packDone, 0);
    chk({tag, "_fmtErr"}, fmtErr, 0);
  endtask

  task automatic check_vec(input int k);
    chk($sformatf("wave%0d_rdEn", k), rdEn, vec[k].rd_en);
    if (vec[k].rd_en) chk($sformatf("wave%0d_rdAddr", k), rdAddr, vec[k].addr);
    chk($sformatf("wave%0d_txStrb", k), txStrb, vec[k].strb);
    chk($sformatf("wave%0d_txBit", k), txBit, vec[k].txb);
    chk($sformatf("wave%0d_busy", k), busy, vec[k].bsy);
  endtask

  // One packet request; expectations come from the RAM contents and the packet index p.
  task automatic run_pack(input int p, input bit clr_start, input bit poke, input bit clr_end, input bit wave);
    int a0, b0, e0, i, nbad;
    bit done;
    logic [10:0] ea[$];
    bit eb[$];
    int eerr[$];
    logic [11:0] d;
    a0 = addr_q.size(); b0 = bit_q.size(); e0 = err_q.size();
    for (int w = 0; w < 16; w++) begin
      ea.push_back(11'(p * 32 + w * 2));
      d = mem[p * 32 + w * 2];
      for (int b = 11; b >= 0; b--) eb.push_back(d[b]);
      if (NB == 13) eb.push_back(~^d);
      if (d[11] || d[2:0] != 3'b000) eerr.push_back(w * PER + 2);
    end
    @(negedge clk); start = 1'b1; clrPack = clr_start;
    @(negedge clk); start = 1'b0; clrPack = 1'b0;
    if (wave) check_vec(0);
    done = 1'b0; i = 0;
    while (!done && i < PKT + 50) begin
      @(negedge clk); i++;
      if (wave && i < VLEN) check_vec(i);
      if (poke) start = (i == 300);
      if (clr_end) clrPack = (i == PKT - 1);
      if (packDone) begin
        done = 1'b1;
        chk($sformatf("p%0d_done_latency", p), i, PKT);
        chk($sformatf("p%0d_busy_at_done", p), busy, 0);
      end
    end
    start = 1'b0; clrPack = 1'b0;
    chk($sformatf("p%0d_done_seen", p), done, 1);
    @(negedge clk);
    chk($sformatf("p%0d_rd_count", p), addr_q.size() - a0, 16);
    nbad = 0;
    for (int j = 0; j < 16 && a0 + j < addr_q.size(); j++) if (addr_q[a0 + j] !== ea[j]) nbad++;
    chk($sformatf("p%0d_addr_mismatches", p), nbad, 0);
    if (addr_q.size() > a0)
      chk($sformatf("p%0d_first_rd_to_done", p), cyc - 1 - rd_cyc_q[a0], PKT);
    chk($sformatf("p%0d_bit_count", p), bit_q.size() - b0, eb.size());
    nbad = 0;
    for (int j = 0; j < eb.size() && b0 + j < bit_q.size(); j++) if (bit_q[b0 + j] !== eb[j]) nbad++;
    chk($sformatf("p%0d_bit_mismatches", p), nbad, 0);
    chk($sformatf("p%0d_fmtErr_count", p), err_q.size() - e0, eerr.size());
    nbad = 0;
    for (int j = 0; j < eerr.size() && e0 + j < err_q.size() && addr_q.size() > a0; j++)
      if (err_q[e0 + j] - rd_cyc_q[a0] != eerr[j]) nbad++;
    chk($sformatf("p%0d_fmtErr_timing", p), nbad, 0);
  endtask

  initial begin
    logic [11:0] d0, r;
    int j;
    d0 = 12'h7F8;
    vec[0] = '{1'b1, 11'd0, 1'b0, 1'b0, 1'b1};
    vec[1] = '{1'b0, 11'd0, 1'b0, 1'b0, 1'b1};
    for (int k = 2; k < VLEN - 1; k++) begin
      j = k - 2;
      vec[k] = '{1'b0, 11'd0, (j % BD) == 0, (j / BD < 12) ? d0[11 - j / BD] : ~^d0, 1'b1};
    end
    vec[VLEN-1] = '{1'b1, 11'd2, 1'b0, 1'b0, 1'b1};

    mem[0] = d0;
    for (int k = 1; k < 16; k++) mem[k * 2] = 12'(k << 3);
    for (int a = 0; a < 2048; a++) begin
      if (a >= 32 || a[0]) begin
        r = 12'($urandom);
        if ($urandom_range(0, 1) == 1) r = r & 12'h7F8;
        mem[a] = r;
      end
    end

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_pack(0, 0, 0, 0, 1);
    for (int p = 1; p < 64; p++) run_pack(p, 0, 0, 0, 0);
    run_pack(0, 0, 0, 0, 0);

    for (int k = 0; k < 16; k++) mem[32 + k * 2] = 12'(k << 3);
    mem[32 + 10] = 12'h801;
    run_pack(1, 0, 0, 0, 0);
    run_pack(2, 0, 0, 0, 0);
    run_pack(3, 0, 1, 0, 0);
    run_pack(0, 1, 0, 0, 0);
    run_pack(1, 0, 0, 1, 0);
    run_pack(0, 0, 0, 0, 0);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7 * PER + 8) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    #2 rst = 1'b0;
    #1 check_outputs_zero("abort");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run_pack(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/orb_reader.md
# orb_reader

Read-side counterpart of the orbital telemetry packer. It fetches one 16-word packet per request from the shared 2048×12 orbital RAM, reading even addresses `(word<<1)+(pack<<5)`. Each 12-bit word is serialized MSB-first onto a bit line with a per-bit strobe. It sits between the RAM read port and the downlink line driver and keeps its own wrapping packet pointer so successive requests walk the buffer in write order.

## Interface
Parameters:
- `WORDS_PER_PACK`, 16: words read per request. Word index is 4 bits wide.
- `PACKS`, 64: packets in the buffer. Packet pointer is 6 bits wide.
- `BIT_DIV`, 4: clock cycles per serial bit. Must be ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request one packet. Level sampled in IDLE only.
- `clrPack` in 1: synchronous clear of the packet pointer to 0.
- `rdData` in 12: RAM read data. Synchronous RAM, valid one cycle after `rdEn`.
- `rdEn` out 1: RAM read enable, one-cycle pulse per word.
- `rdAddr` out 11: RAM read address.
- `txBit` out 1: serial data, MSB first.
- `txStrb` out 1: high on the first cycle of each bit period.
- `busy` out 1: high from the cycle after `start` is accepted until packet end.
- `packDone` out 1: one-cycle pulse after the last bit of word 15.
- `fmtErr` out 1: one-cycle pulse when a word is loaded with `rdData[11]`≠0 or `rdData[2:0]`≠0.

## Operation
- FSM states: IDLE, FETCH, LATCH, SHIFT.
- IDLE → FETCH when `start`=1.
  - Registers `rdEn`=1 and `rdAddr` = (`cntWrd`<<1) + (`cntPack`<<5), with `cntWrd`=0. Sets `busy`=1.
- FETCH → LATCH unconditionally. `rdEn` returns to 0.
- LATCH → SHIFT unconditionally.
  - Loads the shift register from `rdData` and the bit counter with 11.
  - Clears the divider. Evaluates `fmtErr`.
- SHIFT: `txBit` = shift-register MSB, held for `BIT_DIV` cycles. `txStrb`=1 on the first cycle of each period.
  - On divider terminal count with bits remaining, shift left and decrement the bit counter.
- End of the last bit period:
  - If `cntWrd`<15: increment `cntWrd`, go to FETCH with the new address.
  - If `cntWrd`=15: clear `cntWrd`, increment `cntPack` (wraps 63→0), pulse `packDone`, clear `busy`, go to IDLE.
- Address arithmetic is 11-bit. Only even addresses are issued. Pack 63, word 15 gives address 2046.
- `clrPack`=1 in any state forces `cntPack`=0 on that edge and takes priority over the end-of-packet increment. If it coincides with an accepted `start`, the fetch uses pack 0.
- `start` while `busy`=1 is ignored. There is no queueing.
- Outside SHIFT: `txBit`=0, `txStrb`=0.

## Timing
- Reset value of all outputs is 0. Internal state resets to IDLE, `cntWrd`=0, `cntPack`=0.
- `start` sampled at edge N gives `rdEn`/`rdAddr` valid after N, data captured at N+2, and the first `txStrb`/`txBit` valid after N+2.
- Per word: 12·`BIT_DIV` cycles in SHIFT, plus a 2-cycle inter-word gap (FETCH, LATCH) with `txStrb`=0.
- Per packet: 16·(12·`BIT_DIV`+2) cycles from first `rdEn` to `packDone`. With defaults this is 800 cycles.
- `packDone` asserts on the edge after the final bit period ends. `busy` falls on the same edge.
- Reset mid-packet aborts immediately: outputs go to 0 and the pointer returns to 0. A partial word is never resumed.

## Configuration
- Macro: `ORB_READER_PARITY_EN`.
- Defined: each word is followed by a 13th bit period carrying odd parity over the 12 data bits, with its own `txStrb`. Per-word time becomes 13·`BIT_DIV`+2.
- Undefined: 12 bits per word, no parity logic.

## Test plan
- Reset, RAM addr0=0x7F8, `start` pulse:
  - `rdAddr`=0 and `rdEn` after edge 1. First `txStrb` after edge 3.
  - Bits 0,1,1,1,1,1,1,1,1,0,0,0, each held 4 cycles.
- Fill packet 0 words with `{0,k,000}`, k=0..15; `start`:
  - Read addresses 0,2,…,30.
  - `packDone` at cycle 800. `cntPack`=1.
  - No `fmtErr`.
- Issue 64 back-to-back packets:
  - 64th reads addresses 2016…2046.
  - 65th reads address 0 again (pointer wrap).
- Word 5 of a packet = 0x801:
  - `fmtErr` pulses once, on the LATCH→SHIFT edge for word 5.
  - Serialization continues unchanged.
- `start` pulsed mid-packet: ignored, no extra `rdEn`.
  - `clrPack` with `start` after pack 3 reads from address 0.
  - `clrPack` coincident with end-of-packet leaves `cntPack`=0.
- Reset asserted during word 7's SHIFT: all outputs 0 asynchronously.
  - Next `start` reads address 0.
  - With `ORB_READER_PARITY_EN`, 0x7F8 gets parity bit 1 and `packDone` arrives at cycle 864.
